// File: rtl/data_mem_responder.sv
// Doubleword-addressed data RAM behind a valid/ready request/response pair.
// Define DMEM_ALIGN_CHECK_EN to reject addresses that are not 8-byte aligned.
module data_mem_responder #(
    parameter int    DEPTH    = 32,
    parameter int    LATENCY  = 2,
    parameter string RAM_FILE = ""
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [63:0] req_addr,
    input  logic [63:0] req_wdata,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [63:0] resp_rdata,
    output logic        resp_error
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [3:0] CNT_INIT = (LATENCY > 0) ? 4'(LATENCY - 1) : 4'd0;

`ifdef DMEM_ALIGN_CHECK_EN
    localparam bit ALIGN_CHECK = 1'b1;
`else
    localparam bit ALIGN_CHECK = 1'b0;
`endif

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t state;
    state_t state_next;

    logic [3:0]    cnt;
    logic          lat_write;
    logic          lat_bad;
    logic [AW-1:0] lat_idx;
    logic [63:0]   lat_wdata;
    logic [63:0]   mem [DEPTH];

    logic          accept;
    logic          access;
    logic          req_bad;
    logic          acc_write;
    logic          acc_bad;
    logic [AW-1:0] acc_idx;
    logic [63:0]   acc_wdata;

    initial begin
        for (int i = 0; i < DEPTH; i++) mem[i] = '0;
    end

    // State register
    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        unique case (state)
            IDLE: if (req_valid)
                      state_next = (LATENCY == 0) ? RESP : WAIT;
            WAIT: if (cnt == 4'd0) state_next = RESP;
            RESP: if (resp_ready)  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        req_ready  = (state == IDLE) && !reset;
        resp_valid = (state == RESP) && !reset;
    end

    always_comb begin
        req_bad = (|req_addr[63:AW+3]) ||
                  (ALIGN_CHECK && (req_addr[2:0] != 3'b000));
        accept  = (state == IDLE) && req_valid && !reset;
        access  = !reset &&
                  (((state == IDLE) && req_valid && (LATENCY == 0)) ||
                   ((state == WAIT) && (cnt == 4'd0)));
    end

    // Zero latency accesses straight from the request bus
    always_comb begin
        if (state == IDLE) begin
            acc_write = req_write;
            acc_bad   = req_bad;
            acc_idx   = req_addr[3 +: AW];
            acc_wdata = req_wdata;
        end else begin
            acc_write = lat_write;
            acc_bad   = lat_bad;
            acc_idx   = lat_idx;
            acc_wdata = lat_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt <= 4'd0;
        end else if (accept) begin
            cnt <= CNT_INIT;
        end else if ((state == WAIT) && (cnt != 4'd0)) begin
            cnt <= cnt - 4'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            lat_write <= 1'b0;
            lat_bad   <= 1'b0;
            lat_idx   <= '0;
            lat_wdata <= '0;
        end else if (accept) begin
            lat_write <= req_write;
            lat_bad   <= req_bad;
            lat_idx   <= req_addr[3 +: AW];
            lat_wdata <= req_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            resp_rdata <= '0;
            resp_error <= 1'b0;
        end else if (access) begin
            resp_error <= acc_bad;
            resp_rdata <= (acc_bad || acc_write) ? 64'd0 : mem[acc_idx];
        end
    end

    // RAM is never touched by reset
    always_ff @(posedge clk) begin
        if (access && !acc_bad && acc_write) mem[acc_idx] <= acc_wdata;
    end

endmodule
